// File: rtl/c_table_builder.sv
// Builds the 4-entry FM-index C-table: counts A/C/G/T in a symbol stream, then writes prefix sums.
// Define C_TABLE_SAT_EN for saturating counters/sums with a sticky overflow flag (default: wrap, overflow=0).
module c_table_builder #(
  parameter int DATA_W   = 8,
  parameter int SENTINEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sym_valid,
  input  logic [1:0]        symbol,
  input  logic              sym_last,
  output logic              sym_ready,
  output logic              wr_en,
  output logic [1:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DATA_W-1:0] SENT_V = DATA_W'(SENTINEL);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_cnt [4];
  logic [DATA_W-1:0] r_acc;
  logic [1:0]        r_idx;

  logic              w_accept;
  logic              w_lastWrite;
  logic [DATA_W-1:0] w_cntNext;
  logic [DATA_W-1:0] w_sumNext;

  assign w_accept    = (r_state == S_COUNT) && sym_valid;
  assign w_lastWrite = (r_idx == 2'd3);

`ifdef C_TABLE_SAT_EN
  localparam logic [DATA_W-1:0] MAX_V = '1;

  logic [DATA_W:0] w_cntFull;
  logic [DATA_W:0] w_sumFull;
  logic            w_cntSat;
  logic            w_sumSat;
  logic            r_overflow;

  assign w_cntFull = {1'b0, r_cnt[symbol]} + {{DATA_W{1'b0}}, 1'b1};
  assign w_sumFull = {1'b0, r_acc} + {1'b0, r_cnt[r_idx]};
  assign w_cntSat  = w_cntFull[DATA_W];
  assign w_sumSat  = w_sumFull[DATA_W];
  assign w_cntNext = w_cntSat ? MAX_V : w_cntFull[DATA_W-1:0];
  assign w_sumNext = w_sumSat ? MAX_V : w_sumFull[DATA_W-1:0];

  // Sticky flag; the sum after entry 3 is never written, so it cannot raise overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_overflow <= 1'b0;
    end else if (w_accept && w_cntSat) begin
      r_overflow <= 1'b1;
    end else if ((r_state == S_WRITE) && !w_lastWrite && w_sumSat) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`else
  assign w_cntNext = r_cnt[symbol] + DATA_W'(1);
  assign w_sumNext = r_acc + r_cnt[r_idx];
  assign overflow  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_idx   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < 4; i++) begin
              r_cnt[i] <= '0;
            end
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (w_accept) begin
            r_cnt[symbol] <= w_cntNext;
            if (sym_last) begin
              r_acc   <= SENT_V;
              r_idx   <= 2'd0;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // r_acc always holds the entry being written this cycle.
          if (w_lastWrite) begin
            r_state <= S_DONE;
          end else begin
            r_acc <= w_sumNext;
            r_idx <= r_idx + 2'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sym_ready = (r_state == S_COUNT);
  assign wr_en     = (r_state == S_WRITE);
  assign wr_addr   = wr_en ? r_idx : 2'd0;
  assign wr_data   = wr_en ? r_acc : '0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_c_table_builder.sv
// Randomised self-checking bench for c_table_builder; the model computes the C-table from symbol counts.
// Honours C_TABLE_SAT_EN the same way as the design.
module tb_c_table_builder;

  localparam int DW   = 8;
  localparam int MAXV = 255;
`ifdef C_TABLE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sym_valid;
  logic [1:0]    symbol;
  logic          sym_last;
  logic          sym_ready;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  wr_t        expQ[$];
  int         capAddr[$];
  int         capData[$];
  logic [1:0] stim[$];
  bit         prevFinal = 1'b0;
  bit         expOverflow = 1'b0;

  c_table_builder #(.DATA_W(DW), .SENTINEL(1)) dut (
    .clk(clk), .rst(rst), .start(start), .sym_valid(sym_valid), .symbol(symbol),
    .sym_last(sym_last), .sym_ready(sym_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference C-table from raw symbol counts, pushed as the write sequence expected.
  task automatic buildExpected(input int cnts[4]);
    int cc[4];
    int c;
    int s;
    bit ovf;
    ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (SAT) begin
        cc[k] = (cnts[k] > MAXV) ? MAXV : cnts[k];
        if (cnts[k] > MAXV) ovf = 1'b1;
      end else begin
        cc[k] = cnts[k] % (MAXV + 1);
      end
    end
    c = 1;
    for (int k = 0; k < 4; k++) begin
      expQ.push_back('{addr: k, data: c});
      if (k < 3) begin
        s = c + cc[k];
        if (s > MAXV) begin
          if (SAT) begin
            c = MAXV;
            ovf = 1'b1;
          end else begin
            c = s % (MAXV + 1);
          end
        end else begin
          c = s;
        end
      end
    end
    expOverflow = ovf;
  endtask

  // Compare process: checks the write port and done pulse on every falling edge.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("done", int'(done), int'(prevFinal));
        prevFinal = 1'b0;
        if (wr_en) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_write", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("wr_addr", int'(wr_addr), e.addr);
            checkOutput("wr_data", int'(wr_data), e.data);
            capAddr.push_back(int'(wr_addr));
            capData.push_back(int'(wr_data));
            if (e.addr == 3) prevFinal = 1'b1;
          end
        end else begin
          checkOutput("idle_addr", int'(wr_addr), 0);
          checkOutput("idle_data", int'(wr_data), 0);
        end
      end
    end
  end

  // Runs one build of stim[]; optional idle cycle before each symbol and a start pulse in WRITE.
  task automatic applyStimulus(input bit gaps, input bit startInWrite);
    int cnts[4];
    int n;
    bit seen;
    cnts = '{0, 0, 0, 0};
    capAddr.delete();
    capData.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_count", int'(busy), 1);
    foreach (stim[i]) begin
      if (gaps) begin
        sym_valid = 1'b0;
        @(posedge clk); #1;
      end
      sym_valid = 1'b1;
      symbol    = stim[i];
      sym_last  = (i == stim.size() - 1);
      checkOutput("sym_ready", int'(sym_ready), 1);
      cnts[stim[i]]++;
      if (sym_last) buildExpected(cnts);
      @(posedge clk); #1;
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    if (startInWrite) begin
      checkOutput("ready_in_write", int'(sym_ready), 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    checkOutput("done_seen", int'(seen), 1);
    checkOutput("overflow", int'(overflow), int'(expOverflow));
    @(posedge clk); #1;
    checkOutput("busy_idle", int'(busy), 0);
    checkOutput("writes_left", expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic checkTable(input string name, input int e0, input int e1, input int e2, input int e3);
    int ref_v[4];
    ref_v = '{e0, e1, e2, e3};
    checkOutput({name, "_count"}, capData.size(), 4);
    if (capData.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput({name, "_addr"}, capAddr[k], k);
        checkOutput({name, "_data"}, capData[k], ref_v[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sym_valid = 1'b0;
    symbol = 2'd0;
    sym_last = 1'b0;
    #12;
    checkOutput("rst_ready", int'(sym_ready), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_wr_en", int'(wr_en), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    stim = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    applyStimulus(1'b0, 1'b0);
    checkTable("acgta", 1, 3, 4, 5);

    applyStimulus(1'b1, 1'b0);
    checkTable("acgta_gaps", 1, 3, 4, 5);

    stim = '{2'd3};
    applyStimulus(1'b0, 1'b1);
    checkTable("t_only", 1, 1, 1, 1);

    // Abort a build with reset mid-stream.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sym_valid = 1'b1;
      symbol = 2'(i);
      @(posedge clk); #1;
    end
    symbol = 2'd1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_ready", int'(sym_ready), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_wr_en", int'(wr_en), 0);
    checkOutput("abort_data", int'(wr_data), 0);
    checkOutput("abort_done", int'(done), 0);
    sym_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_idle", int'(busy), 0);
    stim = '{2'd2};
    applyStimulus(1'b0, 1'b0);
    checkTable("g_only", 1, 1, 1, 2);

    stim.delete();
    for (int i = 0; i < 300; i++) stim.push_back(2'd0);
    stim.push_back(2'd1);
    applyStimulus(1'b0, 1'b0);
    if (SAT) begin
      checkTable("a300", 1, 255, 255, 255);
      checkOutput("a300_ovf", int'(overflow), 1);
    end else begin
      checkTable("a300", 1, 45, 46, 46);
      checkOutput("a300_ovf", int'(overflow), 0);
    end

    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(1, 40);
      stim.delete();
      for (int i = 0; i < len; i++) stim.push_back(2'($urandom_range(0, 3)));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c_table_builder.md
C_TABLE_BUILDER -- requirements
Module: c_table_builder

Interface
REQ-001 Parameter: DATA_W, 8, width of count and C-table entries (matches the C-table ROM data width).
REQ-002 Parameter: SENTINEL, 1, initial offset added to C[A] for the '$' terminator.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a new build; honoured only in IDLE.
REQ-006 sym_valid  input  1  symbol stream valid.
REQ-007 symbol  input  2  base code: 00=A, 01=C, 10=G, 11=T.
REQ-008 sym_last  input  1  marks the final symbol of the stream; qualified by sym_valid & sym_ready.
REQ-009 sym_ready  output  1  block accepts a symbol this cycle.
REQ-010 wr_en  output  1  C-table write strobe.
REQ-011 wr_addr  output  2  C-table entry index (symbol code).
REQ-012 wr_data  output  DATA_W  C-table entry value.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse after the last table write.
REQ-015 overflow  output  1  sticky count/sum overflow indication.

Function
REQ-016 The FSM SHALL have states IDLE, COUNT, WRITE, DONE.
REQ-017 IDLE: start=1 SHALL clear all four counters and overflow and enter COUNT on the next edge.
REQ-018 COUNT: sym_ready SHALL be 1; each cycle with sym_valid&sym_ready SHALL increment cnt[symbol] by 1.
REQ-019 COUNT: accepting a symbol with sym_last=1 SHALL count that symbol and enter WRITE on the next edge; sym_valid=0 cycles SHALL hold all state.
REQ-020 sym_ready SHALL be 0 in IDLE, WRITE and DONE.
REQ-021 WRITE: 4 consecutive cycles with wr_en=1 and wr_addr=0,1,2,3 in order.
REQ-022 wr_data SHALL be the prefix sum: C[0]=SENTINEL, C[k]=C[k-1]+cnt[k-1] for k=1..3, with a running accumulator updated each WRITE cycle.
REQ-023 After the wr_addr=3 cycle the FSM SHALL enter DONE; DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-024 start outside IDLE SHALL be ignored with no effect on counters or FSM.
REQ-025 wr_en SHALL be 0 outside WRITE; wr_addr and wr_data SHALL be 0 when wr_en=0.
REQ-026 Counter values SHALL remain readable by the accumulator until the next start; they are cleared only by start in IDLE or by rst.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, all counters 0, accumulator 0, overflow 0, and sym_ready, wr_en, wr_addr, wr_data, busy, done all 0.
REQ-028 rst during COUNT or WRITE SHALL abort the build; no further writes occur until a new start.

Configuration
REQ-029 Macro C_TABLE_SAT_EN defined: counters and prefix sums SHALL saturate at 2^DATA_W-1, and overflow SHALL set (sticky) on any saturation event.
REQ-030 C_TABLE_SAT_EN undefined: counters and sums SHALL wrap modulo 2^DATA_W and overflow SHALL be constant 0.

Verification
REQ-031 start, stream A,C,G,T,A (sym_last on 5th) -> writes (0,1),(1,3),(2,4),(3,5) on 4 consecutive cycles, then a done pulse, overflow=0.
REQ-032 Same stream with sym_valid low on alternate cycles -> identical writes; counts unaffected by idle cycles.
REQ-033 Single symbol T with sym_last=1 -> writes 1,1,1,1; start pulsed during WRITE -> no effect, exactly 4 writes.
REQ-034 rst asserted after 3 accepted symbols -> outputs 0 the same cycle, FSM IDLE; new start with stream G -> writes 1,1,1,2.
REQ-035 300 consecutive A then C(last): with C_TABLE_SAT_EN -> writes 1,255,255,255, overflow=1; without -> writes 1,45,46,46, overflow=0.
